// File: rtl/fan_pkg.sv
// Shared definitions for the fan auto-off timer: state encoding, digit width
// and the single-digit BCD borrow helper.
package fan_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_RUN   = 3'b010,
    S_PAUSE = 3'b100
  } state_t;

  // Returns {borrow_out, digit}; a borrowed-from 0 becomes 9.
  function automatic logic [BCD_W:0] bcd_digit_dec(input logic [BCD_W-1:0] d,
                                                   input logic             bin);
    if (!bin)
      return {1'b0, d};
    if (d == '0)
      return {1'b1, BCD_W'(9)};
    return {1'b0, d - BCD_W'(1)};
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles;
// holds while disabled and restarts from 0 on clear.
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && !clear && (cnt_q == LAST);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)
      cnt_q <= '0;
    else if (clear)
      cnt_q <= '0;
    else if (enable)
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/fan_off_timer.sv
// Fan auto-off countdown: button-selected BCD presets counted down once per
// second with pause/resume/cancel and a one-cycle timer_done on expiry.
module fan_off_timer
  import fan_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned N_PRESETS = 4,
  parameter logic [N_PRESETS*4*DIGITS-1:0] PRESETS = {8'h10, 8'h05, 8'h03, 8'h00}
) (
  input  logic                         clk,
  input  logic                         reset_p,
  input  logic                         btn_next,
  input  logic                         btn_pause,
  input  logic                         btn_cancel,
  output logic [4*DIGITS-1:0]          bcd_out,
  output logic [$clog2(N_PRESETS)-1:0] preset_idx,
  output logic                         running,
  output logic                         paused,
  output logic                         timer_done
);

  localparam int unsigned CW = BCD_W * DIGITS;
  localparam int unsigned IW = $clog2(N_PRESETS);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_PRESETS - 1);
  localparam logic [CW-1:0] BCD_ONE  = CW'(1);

  state_t        state_q;
  logic [CW-1:0] bcd_q;
  logic [IW-1:0] idx_q;
  logic          running_q, paused_q, done_q;

  logic [IW-1:0] idx_d;
  logic [CW-1:0] preset_d, bcd_dec_d;
  logic          load_off_d;
  logic          tick;

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_p(reset_p),
    .enable (state_q == S_RUN),
    .clear  (btn_next),
    .tick   (tick)
  );

  // Slot selected by btn_next; slot 0 and zero-valued presets both mean "off".
  always_comb begin
    if (state_q == S_IDLE)
      idx_d = IW'(1);
    else if (idx_q == IDX_LAST)
      idx_d = '0;
    else
      idx_d = idx_q + IW'(1);
    preset_d   = PRESETS[idx_d*CW +: CW];
    load_off_d = (idx_d == '0) || (preset_d == '0);
  end

  always_comb begin
    logic             borrow;
    logic [BCD_W:0]   r;
    bcd_dec_d = bcd_q;
    borrow    = 1'b1;
    r         = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r                            = bcd_digit_dec(bcd_q[i*BCD_W +: BCD_W], borrow);
      bcd_dec_d[i*BCD_W +: BCD_W]  = r[BCD_W-1:0];
      borrow                       = r[BCD_W];
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      idx_q     <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && btn_cancel) begin
        state_q   <= S_IDLE;
        bcd_q     <= '0;
        idx_q     <= '0;
        running_q <= 1'b0;
        paused_q  <= 1'b0;
      end else if (btn_next) begin
        if (load_off_d) begin
          state_q   <= S_IDLE;
          bcd_q     <= '0;
          idx_q     <= '0;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
        end else begin
          state_q   <= S_RUN;
          bcd_q     <= preset_d;
          idx_q     <= idx_d;
          running_q <= 1'b1;
          paused_q  <= 1'b0;
        end
      end else if (state_q == S_RUN && btn_pause) begin
        state_q   <= S_PAUSE;
        running_q <= 1'b0;
        paused_q  <= 1'b1;
      end else if (state_q == S_PAUSE && btn_pause) begin
        state_q   <= S_RUN;
        running_q <= 1'b1;
        paused_q  <= 1'b0;
      end else if (state_q == S_RUN && tick) begin
        if (bcd_q == BCD_ONE) begin
          state_q   <= S_IDLE;
          bcd_q     <= '0;
          idx_q     <= '0;
          running_q <= 1'b0;
          paused_q  <= 1'b0;
          done_q    <= 1'b1;
        end else begin
          bcd_q <= bcd_dec_d;
        end
      end
    end
  end

  assign bcd_out    = bcd_q;
  assign preset_idx = idx_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign timer_done = done_q;

endmodule
